trdb_reg_multi: RTL and testbench

Memory-mapped control/status register block for the trace debugger, generalised to NUM_RANGES address-range comparators.
- Adds sticky write-1-to-clear status bits and self-clearing control bits.
- Integrates a parametrised software-dump FIFO with drop accounting.
- Sits between the APB peripheral port and the trace filter, packet streamer and timer unit.

---
 rtl/trdb_reg_multi.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_trdb_reg_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_reg_multi.sv
// rtl/trdb_reg_multi.sv - trace debugger control/status registers with NUM_RANGES comparators and software-dump FIFO
// Optional: define TRDB_REG_CLOCK_GATING_EN to clock non-CTRL/non-FIFO registers through a pulp_clock_gating cell (adds test_mode_i).
module trdb_reg_multi #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_RANGES     = 4,
    parameter int unsigned SW_FIFO_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
`ifdef TRDB_REG_CLOCK_GATING_EN
    input  logic                         test_mode_i,
`endif
    output logic [31:0]                  per_rdata_o,
    output logic                         per_ready_o,
    input  logic [31:0]                  per_wdata_i,
    input  logic [APB_ADDR_WIDTH-1:0]    per_addr_i,
    input  logic                         per_we_i,
    input  logic                         per_valid_i,
    output logic                         flush_stream_o,
    input  logic                         flush_confirm_i,
    output logic                         clear_fifo_o,
    output logic                         trace_enable_o,
    output logic                         trace_activated_o,
    output logic                         trace_full_addr_o,
    input  logic                         trace_req_deactivate_i,
    output logic                         apply_filters_o,
    output logic                         trace_selected_priv_o,
    output logic [1:0]                   trace_which_priv_o,
    output logic                         trace_range_event_o,
    output logic                         trace_stop_event_o,
    output logic [NUM_RANGES-1:0]        range_en_o,
    output logic [NUM_RANGES*XLEN-1:0]   range_lower_o,
    output logic [NUM_RANGES*XLEN-1:0]   range_higher_o,
    input  logic                         trace_qualified_i,
    input  logic                         trace_priv_match_i,
    input  logic [NUM_RANGES-1:0]        trace_range_match_i,
    input  logic                         trace_fifo_overflow_i,
    input  logic                         external_fifo_overflow_i,
    output logic [XLEN-1:0]              sw_word_o,
    output logic                         sw_valid_o,
    input  logic                         sw_grant_i,
    output logic                         tu_req_o
);

    localparam int unsigned FIFO_AW = (SW_FIFO_DEPTH > 1) ? $clog2(SW_FIFO_DEPTH) : 1;
    localparam int unsigned FIFO_CW = FIFO_AW + 1;
    localparam logic [FIFO_CW-1:0] FIFO_FULL_LVL = FIFO_CW'(SW_FIFO_DEPTH);

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_STATUS     = 8'h04;
    localparam logic [7:0] ADDR_FILTER     = 8'h08;
    localparam logic [7:0] ADDR_DUMP       = 8'h0C;
    localparam logic [7:0] ADDR_DUMP_TIME  = 8'h10;
    localparam logic [7:0] ADDR_SWF_STAT   = 8'h14;
    localparam logic [7:0] ADDR_RANGE_BASE = 8'h40;

    localparam int unsigned CTRL_ENABLE    = 0;
    localparam int unsigned CTRL_ACTIVATED = 1;
    localparam int unsigned CTRL_CLEAR     = 2;
    localparam int unsigned CTRL_FLUSH     = 3;
    localparam int unsigned CTRL_FULL_ADDR = 4;

    // register state
    logic [4:0]            ctrl_q;
    logic [5:0]            filter_q;
    logic [NUM_RANGES-1:0] range_en_q;
    logic [XLEN-1:0]       lower_q  [NUM_RANGES];
    logic [XLEN-1:0]       higher_q [NUM_RANGES];
    logic                  qualified_q;
    logic                  priv_match_q;
    logic [NUM_RANGES-1:0] range_match_q;
    logic                  sticky_trace_ovf_q;
    logic                  sticky_ext_ovf_q;
    logic                  sticky_sw_drop_q;

    // software FIFO state
    logic [XLEN-1:0]       fifo_mem_q [SW_FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wptr_q;
    logic [FIFO_AW-1:0]    rptr_q;
    logic [FIFO_CW-1:0]    count_q;
    logic [7:0]            drop_cnt_q;
    logic                  tu_req_q;

    logic                  reg_clk;

`ifdef TRDB_REG_CLOCK_GATING_EN
    pulp_clock_gating i_reg_clk_gate (
        .clk_i     (clk_i),
        .en_i      (ctrl_q[CTRL_ENABLE]),
        .test_en_i (test_mode_i),
        .clk_o     (reg_clk)
    );
`else
    assign reg_clk = clk_i;
`endif

    // access decode
    logic [7:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] range_off;
    logic       range_space;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_filter;
    logic       wr_swf_stat;
    logic       push_req;
    logic       push_is_timed;

    assign addr          = per_addr_i[7:0];
    assign wr            = per_valid_i & per_we_i;
    assign rd            = per_valid_i & ~per_we_i;
    assign range_off     = addr - ADDR_RANGE_BASE;
    assign range_space   = (addr >= ADDR_RANGE_BASE) && (range_off[1:0] == 2'b00);
    assign wr_ctrl       = wr && (addr == ADDR_CTRL);
    assign wr_status     = wr && (addr == ADDR_STATUS);
    assign wr_filter     = wr && (addr == ADDR_FILTER);
    assign wr_swf_stat   = wr && (addr == ADDR_SWF_STAT);
    assign push_is_timed = (addr == ADDR_DUMP_TIME);
    assign push_req      = wr && ((addr == ADDR_DUMP) || push_is_timed);

    logic unused_addr_bits;
    assign unused_addr_bits = ^per_addr_i[APB_ADDR_WIDTH-1:8];

    // FIFO handshake; CLEAR_FIFO overrides pushes, pops and drops for its cycle
    logic fifo_clear;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_ok;
    logic sw_drop;

    assign fifo_clear = ctrl_q[CTRL_CLEAR];
    assign fifo_full  = (count_q == FIFO_FULL_LVL);
    assign fifo_empty = (count_q == '0);
    assign pop        = sw_grant_i & ~fifo_empty & ~fifo_clear;
    assign push_ok    = push_req & ~fifo_clear & (~fifo_full | pop);
    assign sw_drop    = push_req & ~fifo_clear & fifo_full & ~pop;

    // CTRL: clear pulse self-clears, flush confirm and hardware deactivation override software writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q[CTRL_ENABLE]    <= per_wdata_i[0];
                ctrl_q[CTRL_ACTIVATED] <= per_wdata_i[1];
                ctrl_q[CTRL_FLUSH]     <= per_wdata_i[3];
                ctrl_q[CTRL_FULL_ADDR] <= per_wdata_i[4];
            end
            ctrl_q[CTRL_CLEAR] <= wr_ctrl & per_wdata_i[2] & ~ctrl_q[CTRL_CLEAR];
            if (trace_req_deactivate_i) begin
                ctrl_q[CTRL_ACTIVATED] <= 1'b0;
            end
            if (flush_confirm_i) begin
                ctrl_q[CTRL_FLUSH] <= 1'b0;
            end
        end
    end

    // FILTER register
    always_ff @(posedge reg_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            filter_q   <= '0;
            range_en_q <= '0;
        end else if (wr_filter) begin
            filter_q   <= per_wdata_i[5:0];
            range_en_q <= per_wdata_i[8 +: NUM_RANGES];
        end
    end

    // range bounds, write-only
    always_ff @(posedge reg_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_RANGES; i++) begin
                lower_q[i]  <= '0;
                higher_q[i] <= '0;
            end
        end else if (wr && range_space) begin
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (range_off[7:3] == 5'(i)) begin
                    if (range_off[2]) begin
                        higher_q[i] <= XLEN'(per_wdata_i);
                    end else begin
                        lower_q[i] <= XLEN'(per_wdata_i);
                    end
                end
            end
        end
    end

    // STATUS: live bits resampled every cycle, sticky bits cleared by writing 1 unless set that cycle
    always_ff @(posedge reg_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            qualified_q        <= 1'b0;
            priv_match_q       <= 1'b0;
            range_match_q      <= '0;
            sticky_trace_ovf_q <= 1'b0;
            sticky_ext_ovf_q   <= 1'b0;
            sticky_sw_drop_q   <= 1'b0;
        end else begin
            qualified_q        <= trace_qualified_i;
            priv_match_q       <= trace_priv_match_i;
            range_match_q      <= trace_range_match_i;
            sticky_trace_ovf_q <= trace_fifo_overflow_i
                                  | (sticky_trace_ovf_q & ~(wr_status & per_wdata_i[2]));
            sticky_ext_ovf_q   <= external_fifo_overflow_i
                                  | (sticky_ext_ovf_q & ~(wr_status & per_wdata_i[3]));
            sticky_sw_drop_q   <= sw_drop
                                  | (sticky_sw_drop_q & ~(wr_status & per_wdata_i[4]));
        end
    end

    // software-dump FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SW_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (fifo_clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem_q[wptr_q] <= XLEN'(per_wdata_i);
                wptr_q             <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // drop accounting and timer request pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            tu_req_q   <= 1'b0;
        end else begin
            if (wr_swf_stat) begin
                drop_cnt_q <= '0;
            end else if (sw_drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            tu_req_q <= push_ok & push_is_timed;
        end
    end

    // readback words
    logic [31:0] status_word;
    logic [31:0] filter_word;
    logic [31:0] swf_stat_word;

    // assemble STATUS, FILTER and SWF_STAT read values
    always_comb begin
        status_word                   = '0;
        status_word[0]                = qualified_q;
        status_word[1]                = priv_match_q;
        status_word[2]                = sticky_trace_ovf_q;
        status_word[3]                = sticky_ext_ovf_q;
        status_word[4]                = sticky_sw_drop_q;
        status_word[8 +: NUM_RANGES]  = range_match_q;

        filter_word                   = '0;
        filter_word[5:0]              = filter_q;
        filter_word[8 +: NUM_RANGES]  = range_en_q;

        swf_stat_word                 = '0;
        swf_stat_word[7:0]            = 8'(count_q);
        swf_stat_word[8]              = fifo_full;
        swf_stat_word[9]              = fifo_empty;
        swf_stat_word[23:16]          = drop_cnt_q;
    end

    // read mux; dump and range addresses read as zero
    always_comb begin
        per_rdata_o = '0;
        if (rd) begin
            case (addr)
                ADDR_CTRL:     per_rdata_o = {27'b0, ctrl_q};
                ADDR_STATUS:   per_rdata_o = status_word;
                ADDR_FILTER:   per_rdata_o = filter_word;
                ADDR_SWF_STAT: per_rdata_o = swf_stat_word;
                default:       per_rdata_o = '0;
            endcase
        end
    end

    assign per_ready_o           = 1'b1;
    assign trace_enable_o        = ctrl_q[CTRL_ENABLE];
    assign trace_activated_o     = ctrl_q[CTRL_ACTIVATED];
    assign clear_fifo_o          = ctrl_q[CTRL_CLEAR];
    assign flush_stream_o        = ctrl_q[CTRL_FLUSH];
    assign trace_full_addr_o     = ctrl_q[CTRL_FULL_ADDR];
    assign apply_filters_o       = filter_q[0];
    assign trace_selected_priv_o = filter_q[1];
    assign trace_which_priv_o    = filter_q[3:2];
    assign trace_range_event_o   = filter_q[4];
    assign trace_stop_event_o    = filter_q[5];
    assign range_en_o            = range_en_q;
    assign sw_word_o             = fifo_mem_q[rptr_q];
    assign sw_valid_o            = ~fifo_empty;
    assign tu_req_o              = tu_req_q;

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_range_out
        assign range_lower_o[g*XLEN +: XLEN]  = lower_q[g];
        assign range_higher_o[g*XLEN +: XLEN] = higher_q[g];
    end

endmodule

// File: tb/tb_trdb_reg_multi.sv
// tb/tb_trdb_reg_multi.sv - directed self-checking bench for trdb_reg_multi
module tb_trdb_reg_multi;

    localparam int AW = 12;
    localparam int XL = 32;
    localparam int NR = 4;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [31:0]     per_rdata_o;
    logic            per_ready_o;
    logic [31:0]     per_wdata_i = '0;
    logic [AW-1:0]   per_addr_i = '0;
    logic            per_we_i = 1'b0;
    logic            per_valid_i = 1'b0;
    logic            flush_stream_o;
    logic            flush_confirm_i = 1'b0;
    logic            clear_fifo_o;
    logic            trace_enable_o;
    logic            trace_activated_o;
    logic            trace_full_addr_o;
    logic            trace_req_deactivate_i = 1'b0;
    logic            apply_filters_o;
    logic            trace_selected_priv_o;
    logic [1:0]      trace_which_priv_o;
    logic            trace_range_event_o;
    logic            trace_stop_event_o;
    logic [NR-1:0]   range_en_o;
    logic [NR*XL-1:0] range_lower_o;
    logic [NR*XL-1:0] range_higher_o;
    logic            trace_qualified_i = 1'b0;
    logic            trace_priv_match_i = 1'b0;
    logic [NR-1:0]   trace_range_match_i = '0;
    logic            trace_fifo_overflow_i = 1'b0;
    logic            external_fifo_overflow_i = 1'b0;
    logic [XL-1:0]   sw_word_o;
    logic            sw_valid_o;
    logic            sw_grant_i = 1'b0;
    logic            tu_req_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    trdb_reg_multi #(
        .APB_ADDR_WIDTH (AW),
        .XLEN           (XL),
        .NUM_RANGES     (NR),
        .SW_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .per_rdata_o              (per_rdata_o),
        .per_ready_o              (per_ready_o),
        .per_wdata_i              (per_wdata_i),
        .per_addr_i               (per_addr_i),
        .per_we_i                 (per_we_i),
        .per_valid_i              (per_valid_i),
        .flush_stream_o           (flush_stream_o),
        .flush_confirm_i          (flush_confirm_i),
        .clear_fifo_o             (clear_fifo_o),
        .trace_enable_o           (trace_enable_o),
        .trace_activated_o        (trace_activated_o),
        .trace_full_addr_o        (trace_full_addr_o),
        .trace_req_deactivate_i   (trace_req_deactivate_i),
        .apply_filters_o          (apply_filters_o),
        .trace_selected_priv_o    (trace_selected_priv_o),
        .trace_which_priv_o       (trace_which_priv_o),
        .trace_range_event_o      (trace_range_event_o),
        .trace_stop_event_o       (trace_stop_event_o),
        .range_en_o               (range_en_o),
        .range_lower_o            (range_lower_o),
        .range_higher_o           (range_higher_o),
        .trace_qualified_i        (trace_qualified_i),
        .trace_priv_match_i       (trace_priv_match_i),
        .trace_range_match_i      (trace_range_match_i),
        .trace_fifo_overflow_i    (trace_fifo_overflow_i),
        .external_fifo_overflow_i (external_fifo_overflow_i),
        .sw_word_o                (sw_word_o),
        .sw_valid_o               (sw_valid_o),
        .sw_grant_i               (sw_grant_i),
        .tu_req_o                 (tu_req_o)
    );

    // all tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        per_addr_i  = a;
        per_wdata_i = d;
        per_we_i    = 1'b1;
        per_valid_i = 1'b1;
        step();
        per_we_i    = 1'b0;
        per_valid_i = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
        per_addr_i  = a;
        per_we_i    = 1'b0;
        per_valid_i = 1'b1;
        #1;
        d = per_rdata_o;
        per_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [15:0] outs;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        apb_read(12'h000, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want %h", r, 32'h0); end
        apb_read(12'h004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h want %h", r, 32'h0); end
        apb_read(12'h008, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_filter got %h want %h", r, 32'h0); end
        apb_read(12'h014, r);
        checks++; if (r !== 32'h200) begin errors++; $display("FAIL reset_swf_stat got %h want %h", r, 32'h200); end
        outs = {flush_stream_o, clear_fifo_o, trace_enable_o, trace_activated_o, trace_full_addr_o,
                apply_filters_o, trace_selected_priv_o, trace_which_priv_o, trace_range_event_o,
                trace_stop_event_o, range_en_o, sw_valid_o};
        checks++; if (outs !== 16'h0 || tu_req_o !== 1'b0) begin errors++; $display("FAIL reset_outputs got %h/%b want 0", outs, tu_req_o); end
        checks++; if (range_lower_o !== '0 || range_higher_o !== '0) begin errors++; $display("FAIL reset_ranges got %h %h want 0", range_lower_o, range_higher_o); end
        checks++; if (per_ready_o !== 1'b1) begin errors++; $display("FAIL ready got %b want 1", per_ready_o); end
    endtask

    task automatic test_clear_fifo();
        logic [31:0] r;
        apb_write(12'h00C, 32'h55);
        checks++; if (sw_valid_o !== 1'b1 || sw_word_o !== 32'h55) begin errors++; $display("FAIL clr_prefill got %b/%h want 1/00000055", sw_valid_o, sw_word_o); end
        apb_write(12'h000, 32'h04);
        checks++; if (clear_fifo_o !== 1'b1) begin errors++; $display("FAIL clr_pulse_hi got %b want 1", clear_fifo_o); end
        step();
        checks++; if (clear_fifo_o !== 1'b0) begin errors++; $display("FAIL clr_pulse_lo got %b want 0", clear_fifo_o); end
        checks++; if (sw_valid_o !== 1'b0) begin errors++; $display("FAIL clr_emptied got %b want 0", sw_valid_o); end
        apb_read(12'h000, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL clr_ctrl_read got %h want %h", r, 32'h0); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        apb_write(12'h000, 32'h0B);
        checks++; if ({flush_stream_o, trace_enable_o, trace_activated_o} !== 3'b111) begin errors++; $display("FAIL flush_set got %b want 111", {flush_stream_o, trace_enable_o, trace_activated_o}); end
        repeat (3) step();
        checks++; if (flush_stream_o !== 1'b1) begin errors++; $display("FAIL flush_hold got %b want 1", flush_stream_o); end
        flush_confirm_i = 1'b1;
        step();
        flush_confirm_i = 1'b0;
        checks++; if (flush_stream_o !== 1'b0) begin errors++; $display("FAIL flush_confirm got %b want 0", flush_stream_o); end
        apb_read(12'h000, r);
        checks++; if (r !== 32'h03) begin errors++; $display("FAIL flush_ctrl_read got %h want %h", r, 32'h03); end
        flush_confirm_i = 1'b1;
        apb_write(12'h000, 32'h0B);
        flush_confirm_i = 1'b0;
        apb_read(12'h000, r);
        checks++; if (r !== 32'h03) begin errors++; $display("FAIL flush_confirm_wins got %h want %h", r, 32'h03); end
        trace_req_deactivate_i = 1'b1;
        apb_write(12'h000, 32'h13);
        trace_req_deactivate_i = 1'b0;
        apb_read(12'h000, r);
        checks++; if (r !== 32'h11) begin errors++; $display("FAIL deactivate got %h want %h", r, 32'h11); end
        checks++; if ({trace_full_addr_o, trace_activated_o} !== 2'b10) begin errors++; $display("FAIL deactivate_outs got %b want 10", {trace_full_addr_o, trace_activated_o}); end
        apb_write(12'h000, 32'h01);
    endtask

    task automatic test_fifo_drops();
        logic [31:0] r;
        for (int i = 0; i < 6; i++) apb_write(12'h00C, 32'hA0 + i);
        checks++; if (tu_req_o !== 1'b0) begin errors++; $display("FAIL drops_no_tu got %b want 0", tu_req_o); end
        apb_read(12'h014, r);
        checks++; if (r !== 32'h0002_0104) begin errors++; $display("FAIL drops_swf_stat got %h want %h", r, 32'h0002_0104); end
        apb_read(12'h004, r);
        checks++; if (r !== 32'h10) begin errors++; $display("FAIL drops_status got %h want %h", r, 32'h10); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sw_valid_o !== 1'b1 || sw_word_o !== 32'hA0 + i) begin errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, sw_valid_o, sw_word_o, 32'hA0 + i); end
            sw_grant_i = 1'b1;
            step();
        end
        sw_grant_i = 1'b0;
        checks++; if (sw_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", sw_valid_o); end
        apb_read(12'h014, r);
        checks++; if (r !== 32'h0002_0200) begin errors++; $display("FAIL drain_swf_stat got %h want %h", r, 32'h0002_0200); end
        apb_write(12'h014, 32'h0);
        apb_read(12'h014, r);
        checks++; if (r !== 32'h200) begin errors++; $display("FAIL drop_cnt_clear got %h want %h", r, 32'h200); end
        apb_write(12'h004, 32'h10);
        apb_read(12'h004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL drop_sticky_clear got %h want %h", r, 32'h0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) apb_write(12'h00C, 32'hB0 + i);
        sw_grant_i = 1'b1;
        apb_write(12'h00C, 32'hB4);
        sw_grant_i = 1'b0;
        apb_read(12'h014, r);
        checks++; if (r !== 32'h104) begin errors++; $display("FAIL b2b_swf_stat got %h want %h", r, 32'h104); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (sw_valid_o !== 1'b1 || sw_word_o !== 32'hB0 + i) begin errors++; $display("FAIL b2b_drain_%0d got %b/%h want 1/%h", i, sw_valid_o, sw_word_o, 32'hB0 + i); end
            sw_grant_i = 1'b1;
            step();
        end
        sw_grant_i = 1'b0;
        checks++; if (sw_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", sw_valid_o); end
    endtask

    task automatic test_sticky();
        logic [31:0] r;
        external_fifo_overflow_i = 1'b1;
        step();
        external_fifo_overflow_i = 1'b0;
        apb_read(12'h004, r);
        checks++; if (r !== 32'h08) begin errors++; $display("FAIL ext_ovf_set got %h want %h", r, 32'h08); end
        apb_write(12'h004, 32'h08);
        apb_read(12'h004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL ext_ovf_clear got %h want %h", r, 32'h0); end
        external_fifo_overflow_i = 1'b1;
        apb_write(12'h004, 32'h08);
        external_fifo_overflow_i = 1'b0;
        apb_read(12'h004, r);
        checks++; if (r !== 32'h08) begin errors++; $display("FAIL ext_ovf_set_wins got %h want %h", r, 32'h08); end
        apb_write(12'h004, 32'h08);
        trace_fifo_overflow_i = 1'b1;
        step();
        trace_fifo_overflow_i = 1'b0;
        apb_read(12'h004, r);
        checks++; if (r !== 32'h04) begin errors++; $display("FAIL trace_ovf_set got %h want %h", r, 32'h04); end
        apb_write(12'h004, 32'h04);
        apb_read(12'h004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL trace_ovf_clear got %h want %h", r, 32'h0); end
    endtask

    task automatic test_live_status();
        logic [31:0] r;
        trace_qualified_i   = 1'b1;
        trace_priv_match_i  = 1'b1;
        trace_range_match_i = 4'b0101;
        step();
        apb_read(12'h004, r);
        checks++; if (r !== 32'h503) begin errors++; $display("FAIL live_status got %h want %h", r, 32'h503); end
        trace_qualified_i   = 1'b0;
        trace_priv_match_i  = 1'b0;
        trace_range_match_i = 4'b0000;
        step();
        apb_read(12'h004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL live_status_drop got %h want %h", r, 32'h0); end
    endtask

    task automatic test_ranges();
        logic [31:0] r;
        apb_write(12'h058, 32'h1000);
        apb_write(12'h05C, 32'h2000);
        apb_write(12'h008, 32'h800);
        checks++; if (range_lower_o[3*XL +: XL] !== 32'h1000) begin errors++; $display("FAIL lower3 got %h want %h", range_lower_o[3*XL +: XL], 32'h1000); end
        checks++; if (range_higher_o[3*XL +: XL] !== 32'h2000) begin errors++; $display("FAIL higher3 got %h want %h", range_higher_o[3*XL +: XL], 32'h2000); end
        checks++; if (range_lower_o[3*XL-1:0] !== '0 || range_higher_o[3*XL-1:0] !== '0) begin errors++; $display("FAIL other_slots got %h %h want 0", range_lower_o[3*XL-1:0], range_higher_o[3*XL-1:0]); end
        checks++; if (range_en_o !== 4'b1000) begin errors++; $display("FAIL range_en got %b want 1000", range_en_o); end
        apb_write(12'h040, 32'h1234);
        checks++; if (range_lower_o[0 +: XL] !== 32'h1234) begin errors++; $display("FAIL lower0 got %h want %h", range_lower_o[0 +: XL], 32'h1234); end
        apb_read(12'h058, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL range_read got %h want %h", r, 32'h0); end
        apb_read(12'h008, r);
        checks++; if (r !== 32'h800) begin errors++; $display("FAIL filter_read got %h want %h", r, 32'h800); end
        apb_write(12'h008, 32'hFFFF_FFFF);
        apb_read(12'h008, r);
        checks++; if (r !== 32'hF3F) begin errors++; $display("FAIL filter_mask got %h want %h", r, 32'hF3F); end
        checks++; if ({apply_filters_o, trace_selected_priv_o, trace_which_priv_o, trace_range_event_o, trace_stop_event_o} !== 6'b111111) begin errors++; $display("FAIL filter_outs got %b want 111111", {apply_filters_o, trace_selected_priv_o, trace_which_priv_o, trace_range_event_o, trace_stop_event_o}); end
        apb_write(12'h020, 32'hFFFF_FFFF);
        apb_read(12'h020, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want %h", r, 32'h0); end
    endtask

    task automatic test_dump_time();
        logic [31:0] r;
        apb_write(12'h010, 32'hC0);
        checks++; if (tu_req_o !== 1'b1 || sw_word_o !== 32'hC0) begin errors++; $display("FAIL dwt_pulse got %b/%h want 1/000000c0", tu_req_o, sw_word_o); end
        step();
        checks++; if (tu_req_o !== 1'b0) begin errors++; $display("FAIL dwt_pulse_end got %b want 0", tu_req_o); end
        apb_read(12'h010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL dwt_read got %h want %h", r, 32'h0); end
        for (int i = 0; i < 3; i++) apb_write(12'h00C, 32'hD0 + i);
        apb_write(12'h010, 32'hDD);
        checks++; if (tu_req_o !== 1'b0) begin errors++; $display("FAIL dwt_full_no_tu got %b want 0", tu_req_o); end
        apb_read(12'h014, r);
        checks++; if (r !== 32'h0001_0104) begin errors++; $display("FAIL dwt_full_stat got %h want %h", r, 32'h0001_0104); end
        checks++; if (sw_word_o !== 32'hC0) begin errors++; $display("FAIL dwt_head got %h want %h", sw_word_o, 32'hC0); end
    endtask

    initial begin
        test_reset();
        test_clear_fifo();
        test_flush();
        test_fifo_drops();
        test_back_to_back();
        test_sticky();
        test_live_status();
        test_ranges();
        test_dump_time();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
